// File: rtl/vend_controller.sv
// vend_controller: multi-product vending FSM with serial 100-yen change payout.
// Define VEND_STOCK_TRACK_EN to enable per-item stock counters, sold_out and refill.
module vend_controller #(
    parameter int N_ITEMS    = 4,
    parameter int CREDIT_W   = 5,
    parameter int MAX_CREDIT = 20,
    parameter int STOCK_W    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        coin_100,
    input  logic                        coin_500,
    input  logic                        bill_1000,
    input  logic                        pull_change,
    input  logic [N_ITEMS-1:0]          select,
    input  logic [N_ITEMS*CREDIT_W-1:0] price,
    input  logic                        refill,
    output logic [N_ITEMS-1:0]          pop_item,
    output logic                        coin_out,
    output logic                        reject,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        busy,
    output logic [N_ITEMS-1:0]          sold_out
);

    typedef enum logic {IDLE, PAYOUT} state_t;

    state_t                state, state_next;
    logic [CREDIT_W-1:0]   change_left, change_next, credit_next;
    logic [N_ITEMS-1:0]    pop_next;
    logic                  coin_next, reject_next;

    logic                  ins_any, ins_extra, ins_fits;
    logic [CREDIT_W:0]     ins_val, ins_sum;
    logic                  sel_found, sel_empty;
    logic [N_ITEMS-1:0]    sel_onehot;
    logic [CREDIT_W-1:0]   sel_price, sel_change;

    assign busy = (state == PAYOUT);

    // Insert decode: highest-ranked insert is credited, any other one forces a reject.
    always_comb begin
        ins_any   = coin_100 | coin_500 | bill_1000;
        ins_extra = 1'b0;
        ins_val   = '0;
        if (coin_100) begin
            ins_val   = (CREDIT_W+1)'(1);
            ins_extra = coin_500 | bill_1000;
        end else if (coin_500) begin
            ins_val   = (CREDIT_W+1)'(5);
            ins_extra = bill_1000;
        end else if (bill_1000) begin
            ins_val   = (CREDIT_W+1)'(10);
        end
        ins_sum  = {1'b0, credit} + ins_val;
        ins_fits = (ins_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    end

    always_comb begin
        sel_found  = 1'b0;
        sel_empty  = 1'b0;
        sel_onehot = '0;
        sel_price  = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (select[i] && !sel_found) begin
                sel_found     = 1'b1;
                sel_onehot[i] = 1'b1;
                sel_price     = price[i*CREDIT_W +: CREDIT_W];
                sel_empty     = sold_out[i];
            end
        end
        sel_change = credit - sel_price;
    end

    always_comb begin
        state_next  = state;
        credit_next = credit;
        change_next = change_left;
        pop_next    = '0;
        coin_next   = 1'b0;
        reject_next = 1'b0;
        case (state)
            IDLE: begin
                if (pull_change && credit != '0) begin
                    change_next = credit;
                    credit_next = '0;
                    state_next  = PAYOUT;
                end else if (ins_any) begin
                    if (ins_fits) credit_next = ins_sum[CREDIT_W-1:0];
                    reject_next = !ins_fits || ins_extra;
                end else if (sel_found && sel_price <= credit && !sel_empty) begin
                    pop_next    = sel_onehot;
                    credit_next = '0;
                    if (sel_change != '0) begin
                        change_next = sel_change;
                        state_next  = PAYOUT;
                    end
                end
            end
            PAYOUT: begin
                coin_next   = 1'b1;
                reject_next = ins_any;
                change_next = change_left - CREDIT_W'(1);
                if (change_left <= CREDIT_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            change_left <= '0;
            pop_item    <= '0;
            coin_out    <= 1'b0;
            reject      <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            change_left <= change_next;
            pop_item    <= pop_next;
            coin_out    <= coin_next;
            reject      <= reject_next;
        end
    end

`ifdef VEND_STOCK_TRACK_EN
    logic [STOCK_W-1:0] stock [N_ITEMS];

    // Refill overrides a same-cycle vend decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ITEMS; i++) stock[i] <= '1;
        end else begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                if (refill)           stock[i] <= '1;
                else if (pop_next[i]) stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) sold_out[i] = (stock[i] == '0);
    end
`else
    logic [STOCK_W-1:0] unused_stock;
    assign unused_stock = {STOCK_W{refill}};
    assign sold_out     = '0;
`endif

endmodule

// File: tb/tb_vend_controller.sv
// Randomised self-checking bench for vend_controller against a coins-owed credit model.
// Honours VEND_STOCK_TRACK_EN the same way as the design (stock depth 3 here).
module tb_vend_controller;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int MAXC = 20;
    localparam int SW   = 2;
    localparam logic [3:0] STOCK_FULL = 4'd3;
`ifdef VEND_STOCK_TRACK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            coin_100 = 1'b0, coin_500 = 1'b0, bill_1000 = 1'b0;
    logic            pull_change = 1'b0, refill = 1'b0;
    logic [N-1:0]    select = '0;
    logic [N*CW-1:0] price;
    logic [N-1:0]    pop_item, sold_out;
    logic            coin_out, reject, busy;
    logic [CW-1:0]   credit;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    vend_controller #(
        .N_ITEMS(N), .CREDIT_W(CW), .MAX_CREDIT(MAXC), .STOCK_W(SW)
    ) dut (
        .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
        .bill_1000(bill_1000), .pull_change(pull_change), .select(select),
        .price(price), .refill(refill), .pop_item(pop_item), .coin_out(coin_out),
        .reject(reject), .credit(credit), .busy(busy), .sold_out(sold_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        int                 credit;
        int                 owed;
        logic [N-1:0][3:0]  stock;
        logic [N-1:0]       pop;
        logic               coin;
        logic               rej;
    } model_t;

    model_t m;

    function automatic int price_of(input int i);
        return int'(price[i*CW +: CW]);
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.credit = 0;
        r.owed   = 0;
        for (int i = 0; i < N; i++) r.stock[i] = STOCK_FULL;
        r.pop  = '0;
        r.coin = 1'b0;
        r.rej  = 1'b0;
        return r;
    endfunction

    // One sampled edge: owed coins drain first, then refund, insert, select.
    function automatic model_t model_next(input model_t cur);
        model_t nx = cur;
        int nins, val, pick;
        nx.pop  = '0;
        nx.coin = 1'b0;
        nx.rej  = 1'b0;
        nins = int'(coin_100) + int'(coin_500) + int'(bill_1000);
        if (cur.owed > 0) begin
            nx.coin = 1'b1;
            nx.owed = cur.owed - 1;
            nx.rej  = (nins != 0);
        end else if (pull_change && cur.credit > 0) begin
            nx.owed   = cur.credit;
            nx.credit = 0;
        end else if (nins != 0) begin
            val = coin_100 ? 1 : (coin_500 ? 5 : 10);
            if (cur.credit + val <= MAXC) nx.credit = cur.credit + val;
            else nx.rej = 1'b1;
            if (nins > 1) nx.rej = 1'b1;
        end else if (select != '0) begin
            pick = 0;
            for (int i = N-1; i >= 0; i--) if (select[i]) pick = i;
            if (price_of(pick) <= cur.credit && (!STOCK_EN || cur.stock[pick] != 4'd0)) begin
                nx.pop[pick] = 1'b1;
                if (STOCK_EN) nx.stock[pick] = cur.stock[pick] - 4'd1;
                nx.owed   = cur.credit - price_of(pick);
                nx.credit = 0;
            end
        end
        if (refill && STOCK_EN)
            for (int i = 0; i < N; i++) nx.stock[i] = STOCK_FULL;
        return nx;
    endfunction

    function automatic logic [N-1:0] exp_sold(input model_t cur);
        logic [N-1:0] s = '0;
        for (int i = 0; i < N; i++) s[i] = STOCK_EN && (cur.stock[i] == 4'd0);
        return s;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_next(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("pop_item", 32'(pop_item), 32'(m.pop));
            check("coin_out", 32'(coin_out), 32'(m.coin));
            check("reject",   32'(reject),   32'(m.rej));
            check("credit",   32'(credit),   m.credit);
            check("busy",     32'(busy),     32'(m.owed > 0));
            check("sold_out", 32'(sold_out), 32'(exp_sold(m)));
        end
    end

    task automatic drive(input logic c1, input logic c5, input logic b10, input logic pc,
                         input logic [N-1:0] sel, input logic rf);
        coin_100 = c1; coin_500 = c5; bill_1000 = b10;
        pull_change = pc; select = sel; refill = rf;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 4'b0000, 0);
    endtask

    initial begin
        int r;
        logic [2:0] ins;
        logic [N-1:0] sel;
        logic pc, rf;

        price = {5'd12, 5'd3, 5'd2, 5'd1};
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_outputs", 32'({pop_item, coin_out, reject, credit, busy, sold_out}), 32'd0);
        reset = 1'b0;
        check_en = 1'b1;
        @(negedge clock);
        check("rst_after", 32'({pop_item, coin_out, reject, credit, busy, sold_out}), 32'd0);

        // Vend item 1 (price 2) from 5 credit: 3 coins of change.
        drive(0, 1, 0, 0, 4'b0000, 0);
        check("vend_credit5", 32'(credit), 32'd5);
        drive(0, 0, 0, 0, 4'b0010, 0);
        check("vend_pop", 32'(pop_item), 32'h2);
        check("vend_credit0", 32'(credit), 32'd0);
        check("vend_busy", 32'(busy), 32'd1);
        drive(0, 0, 0, 0, 4'b0000, 0);
        check("vend_pop_once", 32'(pop_item), 32'h0);
        check("vend_coin1", 32'(coin_out), 32'd1);
        idle(1);
        check("vend_coin2", 32'(coin_out), 32'd1);
        idle(1);
        check("vend_coin3", 32'(coin_out), 32'd1);
        idle(1);
        check("vend_coin_end", 32'(coin_out), 32'd0);
        check("vend_busy_end", 32'(busy), 32'd0);

        // Overflow handling around the 20-unit ceiling.
        drive(0, 1, 0, 0, 4'b0000, 0);
        drive(0, 0, 1, 0, 4'b0000, 0);
        check("ovf_credit15", 32'(credit), 32'd15);
        drive(0, 0, 1, 0, 4'b0000, 0);
        check("ovf_reject", 32'(reject), 32'd1);
        check("ovf_hold15", 32'(credit), 32'd15);
        idle(1);
        check("ovf_reject_pulse", 32'(reject), 32'd0);
        drive(0, 1, 0, 0, 4'b0000, 0);
        check("ovf_credit20", 32'(credit), 32'd20);
        drive(1, 1, 0, 0, 4'b0000, 0);
        check("dual_reject", 32'(reject), 32'd1);
        check("dual_hold20", 32'(credit), 32'd20);
        drive(0, 0, 0, 1, 4'b0000, 0);
        idle(22);
        check("ovf_drained", 32'(busy), 32'd0);

        // Insufficient credit, then refund of 1.
        drive(1, 0, 0, 0, 4'b0000, 0);
        drive(0, 0, 0, 0, 4'b0100, 0);
        check("short_nopop", 32'(pop_item), 32'h0);
        check("short_credit1", 32'(credit), 32'd1);
        drive(0, 0, 0, 1, 4'b0000, 0);
        check("refund_credit0", 32'(credit), 32'd0);
        idle(1);
        check("refund_coin", 32'(coin_out), 32'd1);
        idle(1);
        check("refund_coin_end", 32'(coin_out), 32'd0);

`ifdef VEND_STOCK_TRACK_EN
        repeat (3) begin
            drive(1, 0, 0, 0, 4'b0000, 0);
            drive(0, 0, 0, 0, 4'b0001, 0);
            check("stock_vend", 32'(pop_item), 32'h1);
        end
        check("stock_soldout", 32'(sold_out), 32'h1);
        drive(1, 0, 0, 0, 4'b0000, 0);
        drive(0, 0, 0, 0, 4'b0001, 0);
        check("stock_blocked", 32'(pop_item), 32'h0);
        check("stock_keep_credit", 32'(credit), 32'd1);
        drive(0, 0, 0, 0, 4'b0000, 1);
        check("refill_clear", 32'(sold_out), 32'h0);
        drive(0, 0, 0, 0, 4'b0001, 0);
        check("refill_vend", 32'(pop_item), 32'h1);
`else
        repeat (4) begin
            drive(1, 0, 0, 0, 4'b0000, 0);
            drive(0, 0, 0, 0, 4'b0001, 0);
            check("nostock_vend", 32'(pop_item), 32'h1);
        end
        check("nostock_soldout", 32'(sold_out), 32'h0);
`endif

        // Reset after the 3rd of 9 change coins.
        drive(0, 1, 0, 0, 4'b0000, 0);
        drive(0, 1, 0, 0, 4'b0000, 0);
        drive(0, 0, 0, 0, 4'b0001, 0);
        check("rst9_pop", 32'(pop_item), 32'h1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("rst9_coin", 32'(coin_out), 32'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("rst9_coin_stop", 32'(coin_out), 32'd0);
        check("rst9_busy", 32'(busy), 32'd0);
        check("rst9_credit", 32'(credit), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle(2);
        check("rst9_after", 32'({coin_out, busy, credit}), 32'd0);

        // Random traffic; pull_change is only ever asserted alone.
        for (int k = 0; k < 3000; k++) begin
            if (k % 600 == 0)
                for (int i = 0; i < N; i++) price[i*CW +: CW] = 5'($urandom_range(0, 12));
            r   = $urandom_range(0, 99);
            ins = 3'b000;
            sel = '0;
            pc  = 1'b0;
            if (r < 25) ins = 3'($urandom_range(1, 7));
            else if (r < 50) sel = 4'($urandom_range(1, 15));
            else if (r < 55) pc = 1'b1;
            else if (r < 62) begin
                ins = 3'($urandom_range(1, 7));
                sel = 4'($urandom_range(1, 15));
            end
            rf = ($urandom_range(0, 39) == 0);
            drive(ins[0], ins[1], ins[2], pc, sel, rf);
        end
        idle(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
